// File: rtl/psram_arbiter.sv
// psram_arbiter: round-robin front end that shares one psram_controller command port between two requesters.
// Optional BUSY watchdog is built when PSRAM_ARB_TIMEOUT_EN is defined.
module psram_arbiter #(
  parameter int         BIT_MODE    = 16,
  parameter bit         WRAP_EN     = 1'b1,
  parameter logic [1:0] CMD_ARRAY   = 2'b00,
  parameter int         TIMEOUT_CYC = 65535
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        init_cable_complete,
  input  logic        m0_req,
  input  logic        m0_rw,
  input  logic [31:0] m0_addr,
  input  logic [11:0] m0_burst_len,
  input  logic [1:0]  m0_byte_write,
  input  logic [15:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_wr_valid,
  output logic        m0_rd_valid,
  output logic [15:0] m0_rd_data,
  output logic        m0_done,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_rw,
  input  logic [31:0] m1_addr,
  input  logic [11:0] m1_burst_len,
  input  logic [1:0]  m1_byte_write,
  input  logic [15:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_wr_valid,
  output logic        m1_rd_valid,
  output logic [15:0] m1_rd_data,
  output logic        m1_done,
  output logic        m1_err,
  output logic        psram_exe,
  output logic        rw_ctrl,
  output logic        bit_ctrl,
  output logic        wrap_in,
  output logic [1:0]  byte_write,
  output logic [31:0] addr_in,
  output logic [15:0] data_in,
  output logic [11:0] burst_len,
  output logic [1:0]  command_in,
  input  logic        psram_done,
  input  logic        psram_wr_valid,
  input  logic        psram_rd_valid,
  input  logic [15:0] psram_rd_data,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, BUSY = 2'd2, DONE = 2'd3} state_t;

  state_t      state;
  logic        owner;
  logic        last;
  logic        win;
  logic        in_busy;
  logic [15:0] m0_rd_hold;
  logic [15:0] m1_rd_hold;

  // The watchdog counter is 16 bits wide, so the limit must fit in it.
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be in 1..65535");
  end

`ifdef PSRAM_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);
  logic [15:0] cnt;
`else
  assign m0_err = 1'b0;
  assign m1_err = 1'b0;
`endif

  assign bit_ctrl   = (BIT_MODE == 16);
  assign wrap_in    = WRAP_EN;
  assign command_in = CMD_ARRAY;
  assign busy       = (state != IDLE);
  assign in_busy    = (state == BUSY);

  // On a conflict the requester that did not finish last wins.
  assign win = (m0_req && m1_req) ? ~last : m1_req;

  // Data-phase routing is combinational so strobes line up with the controller.
  assign data_in     = in_busy ? (owner ? m1_wdata : m0_wdata) : 16'h0000;
  assign m0_wr_valid = in_busy && !owner && psram_wr_valid;
  assign m1_wr_valid = in_busy &&  owner && psram_wr_valid;
  assign m0_rd_valid = in_busy && !owner && psram_rd_valid;
  assign m1_rd_valid = in_busy &&  owner && psram_rd_valid;
  assign m0_rd_data  = m0_rd_valid ? psram_rd_data : m0_rd_hold;
  assign m1_rd_data  = m1_rd_valid ? psram_rd_data : m1_rd_hold;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last       <= 1'b1;
      m0_gnt     <= 1'b0;
      m1_gnt     <= 1'b0;
      m0_done    <= 1'b0;
      m1_done    <= 1'b0;
      psram_exe  <= 1'b0;
      rw_ctrl    <= 1'b0;
      addr_in    <= 32'h0;
      burst_len  <= 12'h0;
      byte_write <= 2'b00;
      m0_rd_hold <= 16'h0;
      m1_rd_hold <= 16'h0;
`ifdef PSRAM_ARB_TIMEOUT_EN
      m0_err     <= 1'b0;
      m1_err     <= 1'b0;
      cnt        <= 16'h0;
`endif
    end else begin
      m0_gnt    <= 1'b0;
      m1_gnt    <= 1'b0;
      m0_done   <= 1'b0;
      m1_done   <= 1'b0;
      psram_exe <= 1'b0;
`ifdef PSRAM_ARB_TIMEOUT_EN
      m0_err    <= 1'b0;
      m1_err    <= 1'b0;
`endif
      if (m0_rd_valid) m0_rd_hold <= psram_rd_data;
      if (m1_rd_valid) m1_rd_hold <= psram_rd_data;

      case (state)
        IDLE: begin
          if (init_cable_complete && (m0_req || m1_req)) begin
            owner      <= win;
            rw_ctrl    <= win ? m1_rw         : m0_rw;
            addr_in    <= win ? m1_addr       : m0_addr;
            burst_len  <= win ? m1_burst_len  : m0_burst_len;
            byte_write <= win ? m1_byte_write : m0_byte_write;
            m0_gnt     <= !win;
            m1_gnt     <= win;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          psram_exe <= 1'b1;
          state     <= BUSY;
`ifdef PSRAM_ARB_TIMEOUT_EN
          cnt       <= 16'h0;
`endif
        end
        BUSY: begin
          if (psram_done) begin
            m0_done <= !owner;
            m1_done <= owner;
            state   <= DONE;
          end
`ifdef PSRAM_ARB_TIMEOUT_EN
          else if (cnt == TO_LAST) begin
            m0_err <= !owner;
            m1_err <= owner;
            last   <= owner;
            state  <= IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
`endif
        end
        DONE: begin
          last  <= owner;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psram_arbiter.sv
// Directed bench for psram_arbiter; the bench itself plays the psram_controller side.
module tb_psram_arbiter;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        init_cable_complete;
  logic        m0_req, m0_rw, m1_req, m1_rw;
  logic [31:0] m0_addr, m1_addr;
  logic [11:0] m0_burst_len, m1_burst_len;
  logic [1:0]  m0_byte_write, m1_byte_write;
  logic [15:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m0_wr_valid, m0_rd_valid, m0_done, m0_err;
  logic        m1_gnt, m1_wr_valid, m1_rd_valid, m1_done, m1_err;
  logic [15:0] m0_rd_data, m1_rd_data;
  logic        psram_exe, rw_ctrl, bit_ctrl, wrap_in, busy;
  logic [1:0]  byte_write, command_in;
  logic [31:0] addr_in;
  logic [15:0] data_in;
  logic [11:0] burst_len;
  logic        psram_done, psram_wr_valid, psram_rd_valid;
  logic [15:0] psram_rd_data;

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  psram_arbiter #(
    .BIT_MODE(16), .WRAP_EN(1'b1), .CMD_ARRAY(2'b00), .TIMEOUT_CYC(20)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .init_cable_complete(init_cable_complete),
    .m0_req(m0_req), .m0_rw(m0_rw), .m0_addr(m0_addr), .m0_burst_len(m0_burst_len),
    .m0_byte_write(m0_byte_write), .m0_wdata(m0_wdata), .m0_gnt(m0_gnt),
    .m0_wr_valid(m0_wr_valid), .m0_rd_valid(m0_rd_valid), .m0_rd_data(m0_rd_data),
    .m0_done(m0_done), .m0_err(m0_err),
    .m1_req(m1_req), .m1_rw(m1_rw), .m1_addr(m1_addr), .m1_burst_len(m1_burst_len),
    .m1_byte_write(m1_byte_write), .m1_wdata(m1_wdata), .m1_gnt(m1_gnt),
    .m1_wr_valid(m1_wr_valid), .m1_rd_valid(m1_rd_valid), .m1_rd_data(m1_rd_data),
    .m1_done(m1_done), .m1_err(m1_err),
    .psram_exe(psram_exe), .rw_ctrl(rw_ctrl), .bit_ctrl(bit_ctrl), .wrap_in(wrap_in),
    .byte_write(byte_write), .addr_in(addr_in), .data_in(data_in), .burst_len(burst_len),
    .command_in(command_in), .psram_done(psram_done), .psram_wr_valid(psram_wr_valid),
    .psram_rd_valid(psram_rd_valid), .psram_rd_data(psram_rd_data), .busy(busy)
  );

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Controller side of a transaction: called in the gnt cycle, returns in the IDLE cycle after DONE.
  task automatic run_txn();
    tick();
    chk("exe_pulse", psram_exe, 1);
    tick();
    chk("exe_single", psram_exe, 0);
    psram_done = 1'b1;
    tick();
    psram_done = 1'b0;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int n_wr, n_gnt, n_exe, err_at, gnt_at;
    sys_rst = 1'b1; init_cable_complete = 1'b0;
    m0_req = 0; m0_rw = 0; m0_addr = 0; m0_burst_len = 0; m0_byte_write = 0; m0_wdata = 0;
    m1_req = 0; m1_rw = 0; m1_addr = 0; m1_burst_len = 0; m1_byte_write = 0; m1_wdata = 0;
    psram_done = 0; psram_wr_valid = 0; psram_rd_valid = 0; psram_rd_data = 0;
    tick(); tick();
    sys_rst = 1'b0;
    tick();

    // Reset state
    chk("rst_busy", busy, 0);
    chk("rst_exe", psram_exe, 0);
    chk("rst_addr", addr_in, 0);
    chk("rst_burst", burst_len, 0);
    chk("rst_gnt", {m0_gnt, m1_gnt}, 0);
    chk("rst_done", {m0_done, m1_done, m0_err, m1_err}, 0);
    chk("rst_data_in", data_in, 0);
    chk("rst_const", {bit_ctrl, wrap_in, command_in}, 4'b1100);

    // m0 write, 4 words to 0x100
    init_cable_complete = 1'b1;
    m0_req = 1; m0_rw = 1; m0_addr = 32'h100; m0_burst_len = 12'd4; m0_byte_write = 2'b11;
    m0_wdata = 16'h1111;
    tick();
    chk("w_gnt", {m0_gnt, m1_gnt}, 2'b10);
    chk("w_busy", busy, 1);
    chk("w_exe_early", psram_exe, 0);
    m0_req = 0;
    tick();
    chk("w_exe", psram_exe, 1);
    chk("w_cmd", {rw_ctrl, byte_write, burst_len, addr_in}, {1'b1, 2'b11, 12'd4, 32'h100});
    tick();
    chk("w_exe_off", psram_exe, 0);
    n_wr = 0;
    for (int i = 0; i < 4; i++) begin
      psram_wr_valid = 1'b1;
      #1;
      if (m0_wr_valid) n_wr++;
      chk("w_data_in", data_in, 32'h1111 + i);
      chk("w_m1_quiet", {m1_wr_valid, m1_rd_valid, m1_gnt, m1_done}, 0);
      tick();
      m0_wdata = m0_wdata + 16'd1;
    end
    psram_wr_valid = 1'b0;
    chk("w_wr_count", n_wr, 4);
    psram_done = 1'b1;
    tick();
    psram_done = 1'b0;
    chk("w_done", {m0_done, m1_done}, 2'b10);
    tick();
    chk("w_done_pulse", {m0_done, busy}, 0);

    // Conflict after reset: m0 first, then m1, then m0 again
    sys_rst = 1'b1; tick(); sys_rst = 1'b0;
    m0_req = 1; m0_rw = 0; m0_addr = 32'h200; m0_burst_len = 12'd1;
    m1_req = 1; m1_rw = 0; m1_addr = 32'h300; m1_burst_len = 12'd1;
    tick();
    chk("c_gnt_m0", {m0_gnt, m1_gnt}, 2'b10);
    m0_req = 0;
    tick();
    chk("c_addr_m0", addr_in, 32'h200);
    tick();
    m0_req = 1;
    psram_done = 1'b1;
    tick();
    psram_done = 1'b0;
    chk("c_done_m0", m0_done, 1);
    tick();
    chk("c_idle_nogrant", {m0_gnt, m1_gnt, busy}, 0);
    tick();
    chk("c_gnt_m1", {m0_gnt, m1_gnt}, 2'b01);
    chk("c_addr_m1", addr_in, 32'h300);
    m1_req = 0;
    run_txn();
    tick();
    chk("c_gnt_m0_again", {m0_gnt, m1_gnt}, 2'b10);
    m0_req = 0;
    run_txn();

    // m1 reads 2 words
    m1_req = 1; m1_rw = 0; m1_addr = 32'h400; m1_burst_len = 12'd2;
    tick();
    chk("r_gnt", m1_gnt, 1);
    m1_req = 0;
    tick(); tick();
    psram_rd_valid = 1'b1; psram_rd_data = 16'hA5A5;
    #1;
    chk("r_v0", {m1_rd_valid, m0_rd_valid}, 2'b10);
    chk("r_d0", m1_rd_data, 16'hA5A5);
    tick();
    psram_rd_data = 16'h5A5A;
    #1;
    chk("r_v1", {m1_rd_valid, m0_rd_valid}, 2'b10);
    chk("r_d1", m1_rd_data, 16'h5A5A);
    tick();
    psram_rd_valid = 1'b0; psram_rd_data = 16'hFFFF;
    #1;
    chk("r_hold", m1_rd_data, 16'h5A5A);
    chk("r_m0_quiet", {m0_rd_valid, m1_rd_valid, m0_rd_data}, 0);
    psram_done = 1'b1;
    tick();
    psram_done = 1'b0;
    chk("r_done", {m0_done, m1_done}, 2'b01);
    tick();

    // Grants held off while init is low
    init_cable_complete = 1'b0;
    m0_req = 1; m0_addr = 32'h500;
    n_gnt = 0; n_exe = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (m0_gnt || m1_gnt) n_gnt++;
      if (psram_exe) n_exe++;
    end
    chk("i_no_gnt", n_gnt, 0);
    chk("i_no_exe", n_exe, 0);
    init_cable_complete = 1'b1;
    tick();
    chk("i_gnt", m0_gnt, 1);
    m0_req = 0;
    run_txn();

    // Reset in BUSY aborts without done
    m0_req = 1; m0_rw = 1; m0_addr = 32'h600; m0_burst_len = 12'd8;
    tick();
    m0_req = 0;
    tick(); tick();
    chk("a_busy", busy, 1);
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    chk("a_idle", busy, 0);
    chk("a_no_done", {m0_done, m1_done, m0_gnt, m1_gnt, psram_exe}, 0);
    chk("a_cmd_clr", {rw_ctrl, burst_len, addr_in}, 0);

`ifdef PSRAM_ARB_TIMEOUT_EN
    // Watchdog: withhold psram_done
    m0_req = 1;
    tick();
    chk("t_gnt", m0_gnt, 1);
    m0_req = 0; m1_req = 1; m1_addr = 32'h700;
    err_at = -1; gnt_at = -1;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (m0_done) chk("t_no_done", m0_done, 0);
      if (m0_err && err_at < 0) err_at = k;
      if (m1_gnt && gnt_at < 0) begin gnt_at = k; m1_req = 0; end
    end
    chk("t_err_cycle", err_at, 21);
    chk("t_m1_gnt_cycle", gnt_at, 22);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
